pulse_width_stats: RTL
======================

# pulse_width_stats

Downstream consumer of the pulse-width measurement stage: takes each 32-bit high-time count (in meaclk cycles) with its capture strobe and reduces windows of 2^LOG2_N samples into average, minimum and maximum width. Publishes results to the DSO register/readout side over a level-valid/ack handshake. Flags loss of signal when no measurement arrives within a programmable timeout.

## Interface
- LOG2_N, 4: window length is 2^LOG2_N samples; legal range 0..8.
- TIMEOUT, 32'd50_000_000: meaclk cycles without width_vld before no_sig asserts; must be at least 1.
- meaclk  in  1  measurement clock; sole clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- width_in  in  32  measured pulse width from the upstream stage.
- width_vld  in  1  one-cycle strobe; width_in is valid in the same cycle.
- clr  in  1  synchronous window restart.
- stats_ack  in  1  consumer acknowledges the current result.
- avg_out  out  32  window average.
- min_out  out  32  window minimum.
- max_out  out  32  window maximum.
- stats_vld  out  1  result registers hold an unacknowledged result.
- ovf  out  1  sticky; a result was overwritten before it was acknowledged.
- no_sig  out  1  timeout reached since the last sample.

## Operation
- Reset values: avg_out, min_out, max_out = 0; stats_vld, ovf, no_sig = 0. Internally: accumulator = 0, sample count = 0, running min = 32'hFFFF_FFFF, running max = 0, idle counter = 0, state = IDLE.
- States:
  - IDLE: entered on reset, on clr, or on timeout. The first width_vld goes to ACCUM and counts as sample 1.
  - ACCUM: each width_vld adds width_in into a (32+LOG2_N)-bit accumulator; the add never wraps. It also updates running min/max (unsigned) and increments the sample count.
  - On the sample that makes count = 2^LOG2_N (the closing sample), the window closes and the block returns to ACCUM with count 0. The accumulator, min and max reload to their empty values, and the closing sample is included in the published result.
- Published result:
  - avg_out = accumulator[LOG2_N +: 32], i.e. truncating divide by 2^LOG2_N.
  - min_out and max_out take the window extrema.
- Handshake:
  - stats_vld rises when a result is loaded.
  - stats_ack with stats_vld = 1 clears stats_vld on the next edge.
  - stats_ack with stats_vld = 0 is ignored.
- Result load and ack in the same cycle: the new result is loaded, stats_vld stays 1, and ovf is not set.
- Result load with stats_vld = 1 and no ack: the result is overwritten and ovf sets. ovf clears only on clr or reset.
- Timeout:
  - The idle counter resets to 0 on width_vld and otherwise increments, saturating at TIMEOUT.
  - When it reaches TIMEOUT, no_sig = 1 and the partial window is discarded (state goes to IDLE).
  - Published result registers and stats_vld are untouched.
  - no_sig clears on the edge that accepts the next width_vld; that sample starts a fresh window.
- clr:
  - Has priority over width_vld in the same cycle, and that sample is dropped.
  - Discards the partial window and clears stats_vld, ovf, no_sig and the idle counter.
  - avg_out, min_out and max_out keep their values.
- width_in = 0 and width_in = 32'hFFFF_FFFF are legal samples. No saturation is required because the accumulator width covers the worst case.

## Timing
- width_vld on the closing sample at edge t: avg_out, min_out, max_out and stats_vld are valid after edge t+1. There is no combinational path from inputs to outputs.
- ack at edge t: stats_vld = 0 after edge t.
- Timeout: TIMEOUT cycles after the last width_vld edge, no_sig = 1 after that edge.
- Back-to-back width_vld on every cycle is supported with no lost samples. Windows abut with no gap cycle.
- LOG2_N = 0: every sample publishes, and avg_out = min_out = max_out = width_in.
- Reset mid-window: all state returns to reset values asynchronously, and the partial window is lost.

## Test plan
- LOG2_N=2; samples 10, 20, 30, 41 on consecutive cycles -> one cycle after the 4th strobe: avg_out=25, min_out=10, max_out=41, stats_vld=1, ovf=0.
- LOG2_N=2; 8 samples all 32'hFFFF_FFFF, no ack -> after the 4th sample: avg_out=32'hFFFF_FFFF. After the 8th: same values, ovf=1.
- LOG2_N=2; ack asserted in the same cycle the second window loads -> stats_vld stays 1, ovf=0. A further ack clears stats_vld the next cycle.
- TIMEOUT=100; 2 samples, then 100 idle cycles -> no_sig=1 and prior outputs are unchanged. The next 4 samples (5, 5, 5, 9) give avg_out=6, no_sig=0 after the first of them.
- LOG2_N=2; 3 samples, then clr coincident with a 4th strobe -> no result is published, stats_vld=0, ovf=0. The next 4 samples of 100 give avg_out=100.
- rst_n low for 1 cycle mid-window with stats_vld=1, ovf=1 -> all outputs 0 immediately. A full 4-sample window afterwards publishes normally.

Source files
------------

// File: rtl/pulse_width_stats_if.sv
// rtl/pulse_width_stats_if.sv - width sample input and statistics readout handshake bundle
interface pulse_width_stats_if;
    logic [31:0] width_in;
    logic        width_vld;
    logic        clr;
    logic        stats_ack;
    logic [31:0] avg_out;
    logic [31:0] min_out;
    logic [31:0] max_out;
    logic        stats_vld;
    logic        ovf;
    logic        no_sig;

    modport master (
        output width_in, width_vld, clr, stats_ack,
        input  avg_out, min_out, max_out, stats_vld, ovf, no_sig
    );

    modport slave (
        input  width_in, width_vld, clr, stats_ack,
        output avg_out, min_out, max_out, stats_vld, ovf, no_sig
    );
endinterface

// File: rtl/pulse_width_stats.sv
// rtl/pulse_width_stats.sv - windowed avg/min/max of pulse widths with loss-of-signal timeout
module pulse_width_stats #(
    parameter int          LOG2_N  = 4,
    parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
    input logic meaclk,
    input logic rst_n,
    pulse_width_stats_if.slave bus
);
    localparam int N  = 1 << LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam int AW = 32 + LOG2_N;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [31:0]   run_min;
    logic [31:0]   run_max;
    logic [31:0]   idle_cnt;

    logic [AW-1:0] acc_base, acc_nxt;
    logic [CW-1:0] cnt_base, cnt_nxt;
    logic [31:0]   min_base, max_base, min_nxt, max_nxt;
    logic          closing;
    logic          timeout_hit;

    // IDLE means "window empty", so the stored accumulators are ignored rather than cleared
    always_comb begin
        acc_base    = (state == IDLE) ? '0 : acc;
        cnt_base    = (state == IDLE) ? '0 : cnt;
        min_base    = (state == IDLE) ? 32'hFFFF_FFFF : run_min;
        max_base    = (state == IDLE) ? 32'h0 : run_max;
        acc_nxt     = acc_base + AW'(bus.width_in);
        cnt_nxt     = cnt_base + CW'(1);
        min_nxt     = (bus.width_in < min_base) ? bus.width_in : min_base;
        max_nxt     = (bus.width_in > max_base) ? bus.width_in : max_base;
        closing     = (cnt_nxt == CW'(N));
        timeout_hit = !bus.width_vld && (idle_cnt >= TIMEOUT - 32'd1);
    end

    always_ff @(posedge meaclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            run_min       <= 32'hFFFF_FFFF;
            run_max       <= 32'h0;
            idle_cnt      <= 32'h0;
            bus.avg_out   <= 32'h0;
            bus.min_out   <= 32'h0;
            bus.max_out   <= 32'h0;
            bus.stats_vld <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.no_sig    <= 1'b0;
        end else if (bus.clr) begin
            state         <= IDLE;
            idle_cnt      <= 32'h0;
            bus.stats_vld <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.no_sig    <= 1'b0;
        end else begin
            if (bus.width_vld) begin
                idle_cnt   <= 32'h0;
                bus.no_sig <= 1'b0;
                state      <= ACCUM;
                if (closing) begin
                    acc           <= '0;
                    cnt           <= '0;
                    run_min       <= 32'hFFFF_FFFF;
                    run_max       <= 32'h0;
                    bus.avg_out   <= acc_nxt[LOG2_N +: 32];
                    bus.min_out   <= min_nxt;
                    bus.max_out   <= max_nxt;
                    bus.stats_vld <= 1'b1;
                    if (bus.stats_vld && !bus.stats_ack)
                        bus.ovf <= 1'b1;
                end else begin
                    acc     <= acc_nxt;
                    cnt     <= cnt_nxt;
                    run_min <= min_nxt;
                    run_max <= max_nxt;
                end
            end else begin
                if (idle_cnt != TIMEOUT)
                    idle_cnt <= idle_cnt + 32'd1;
                if (timeout_hit) begin
                    bus.no_sig <= 1'b1;
                    state      <= IDLE;
                end
            end
            // a load in the same cycle as an ack keeps stats_vld set for the new result
            if (!(bus.width_vld && closing) && bus.stats_ack)
                bus.stats_vld <= 1'b0;
        end
    end
endmodule
